// File: rtl/ysyx_25020077_core_ctrl.sv
// Multi-cycle core sequencer: IDLE -> FETCH -> WAIT -> EXEC, with sticky HALT on break or fetch fault.
// Optional performance counters are enabled with YSYX_25020077_CORE_CTRL_PERF_EN.
module ysyx_25020077_core_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_ifu_req_valid,
  input  logic        io_ifu_req_ready,
  output logic [31:0] io_ifu_req_addr,
  input  logic        io_ifu_resp_valid,
  input  logic [31:0] io_ifu_resp_data,
  input  logic        io_ifu_resp_err,
  output logic [31:0] io_inst,
  input  logic        io_is_break,
  output logic        io_rf_wen,
  output logic [31:0] io_pc,
  output logic        io_halt,
  output logic        io_halt_err,
  output logic [31:0] io_cycle_cnt,
  output logic [31:0] io_retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_req_valid;
  logic        r_halt;
  logic        r_halt_err;
  logic        w_rf_wen;

  // The decoder's break flag is only known once io_inst is presented, so the
  // write enable is qualified by it within the EXEC cycle itself.
  assign w_rf_wen = (r_state == S_EXEC) && !io_is_break;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= 32'h0;
      r_req_valid <= 1'b0;
      r_halt      <= 1'b0;
      r_halt_err  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state     <= S_FETCH;
          r_req_valid <= 1'b1;
        end
        S_FETCH: begin
          if (io_ifu_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (io_ifu_resp_valid) begin
            if (io_ifu_resp_err) begin
              r_halt     <= 1'b1;
              r_halt_err <= 1'b1;
              r_state    <= S_HALT;
            end else begin
              r_inst  <= io_ifu_resp_data;
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (io_is_break) begin
            r_halt  <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_pc        <= r_pc + 32'd4;
            r_state     <= S_FETCH;
            r_req_valid <= 1'b1;
          end
        end
        S_HALT: begin
          r_state     <= S_HALT;
          r_req_valid <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef YSYX_25020077_CORE_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle_cnt  <= 32'h0;
      r_retire_cnt <= 32'h0;
    end else begin
      if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_rf_wen) r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign io_cycle_cnt  = r_cycle_cnt;
  assign io_retire_cnt = r_retire_cnt;
`else
  assign io_cycle_cnt  = 32'h0;
  assign io_retire_cnt = 32'h0;
`endif

  assign io_ifu_req_valid = r_req_valid;
  assign io_ifu_req_addr  = r_pc;
  assign io_pc            = r_pc;
  assign io_inst          = r_inst;
  assign io_rf_wen        = w_rf_wen;
  assign io_halt          = r_halt;
  assign io_halt_err      = r_halt_err;

endmodule

// File: tb/tb_ysyx_25020077_core_ctrl.sv
// Directed bench for ysyx_25020077_core_ctrl; accepted fetch responses are queued
// with their PC and retired against the DUT in EXEC.
module tb_ysyx_25020077_core_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic        resp_err = 1'b0;
  logic [31:0] inst;
  logic        is_break = 1'b0;
  logic        rf_wen;
  logic [31:0] pc;
  logic        halt;
  logic        halt_err;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  logic        d2_req_valid;
  logic [31:0] d2_req_addr;
  logic [31:0] d2_inst;
  logic        d2_rf_wen;
  logic [31:0] d2_pc;
  logic        d2_halt;
  logic        d2_halt_err;
  logic [31:0] d2_cycle_cnt;
  logic [31:0] d2_retire_cnt;

  always #5 clock = ~clock;

  ysyx_25020077_core_ctrl dut (
    .clock(clock), .reset(reset),
    .io_ifu_req_valid(req_valid), .io_ifu_req_ready(req_ready), .io_ifu_req_addr(req_addr),
    .io_ifu_resp_valid(resp_valid), .io_ifu_resp_data(resp_data), .io_ifu_resp_err(resp_err),
    .io_inst(inst), .io_is_break(is_break), .io_rf_wen(rf_wen), .io_pc(pc),
    .io_halt(halt), .io_halt_err(halt_err), .io_cycle_cnt(cycle_cnt), .io_retire_cnt(retire_cnt)
  );

  // Free-running instance at the top of the address space to exercise PC wrap.
  ysyx_25020077_core_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset),
    .io_ifu_req_valid(d2_req_valid), .io_ifu_req_ready(1'b1), .io_ifu_req_addr(d2_req_addr),
    .io_ifu_resp_valid(1'b1), .io_ifu_resp_data(32'h0000_0013), .io_ifu_resp_err(1'b0),
    .io_inst(d2_inst), .io_is_break(1'b0), .io_rf_wen(d2_rf_wen), .io_pc(d2_pc),
    .io_halt(d2_halt), .io_halt_err(d2_halt_err), .io_cycle_cnt(d2_cycle_cnt), .io_retire_cnt(d2_retire_cnt)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc   = 32'h8000_0000;
  logic [31:0] exp_inst = 32'h0;
  logic [31:0] exp_cyc  = 32'h0;
  logic [31:0] exp_ret  = 32'h0;
  bit          exp_halt = 1'b0;
  logic [63:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef YSYX_25020077_CORE_CTRL_PERF_EN
    return v;
`else
    return v & 32'h0;
`endif
  endfunction

  task automatic step();
    if (reset) exp_cyc = 32'h0;
    else if (!exp_halt) exp_cyc = exp_cyc + 32'd1;
    @(posedge clock);
    #1;
  endtask

  // Entered with the DUT in FETCH, one time unit after a clock edge.
  task automatic do_instr(input logic [31:0] data, input int rdy_dly, input bit brk,
                          input bit err, input bit early);
    logic [63:0] e;
    for (int i = 0; i < rdy_dly; i++) begin
      req_ready  = 1'b0;
      resp_valid = 1'b1;  // stray faulting response outside WAIT must be ignored
      resp_err   = 1'b1;
      #1;
      check("stall_req_valid", req_valid, 1);
      check("stall_req_addr", req_addr, exp_pc);
      check("stall_no_halt", halt, 0);
      step();
    end
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    req_ready  = 1'b1;
    if (early) begin
      resp_valid = 1'b1;
      resp_data  = 32'hDEAD_BEEF;
    end
    #1;
    check("fetch_req_valid", req_valid, 1);
    check("fetch_req_addr", req_addr, exp_pc);
    check("fetch_cycle_cnt", cycle_cnt, perf(exp_cyc));
    step();
    req_ready = 1'b0;
    if (early) begin
      resp_valid = 1'b0;
      #1;
      check("wait_req_low", req_valid, 0);
      step();
      check("early_resp_ignored", inst, exp_inst);
      check("early_no_wen", rf_wen, 0);
    end
    resp_valid = 1'b1;
    resp_data  = data;
    resp_err   = err;
    if (!err) sb.push_back({data, exp_pc});
    #1;
    check("wait_req_low", req_valid, 0);
    step();
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = 32'h0;
    if (err) begin
      exp_halt = 1'b1;
      check("err_halt", halt, 1);
      check("err_halt_err", halt_err, 1);
      check("err_inst_kept", inst, exp_inst);
      return;
    end
    is_break = brk;
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      check("exec_inst", inst, e[63:32]);
      check("exec_pc", pc, e[31:0]);
    end
    exp_inst = data;
    check("exec_rf_wen", rf_wen, {31'h0, !brk});
    check("exec_cycle_cnt", cycle_cnt, perf(exp_cyc));
    step();
    is_break = 1'b0;
    if (brk) begin
      exp_halt = 1'b1;
      check("brk_halt", halt, 1);
      check("brk_halt_err", halt_err, 0);
      check("brk_pc_kept", pc, exp_pc);
      for (int i = 0; i < 20; i++) begin
        check("halt_no_req", req_valid, 0);
        check("halt_no_wen", rf_wen, 0);
        step();
      end
      check("halt_pc_frozen", pc, exp_pc);
      check("halt_inst_frozen", inst, exp_inst);
      check("halt_cycle_frozen", cycle_cnt, perf(exp_cyc));
    end else begin
      exp_pc  = exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
      check("retire_pc", pc, exp_pc);
      check("retire_req_valid", req_valid, 1);
      check("retire_cnt", retire_cnt, perf(exp_ret));
    end
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    exp_halt = 1'b0;
    exp_pc   = 32'h8000_0000;
    exp_inst = 32'h0;
    exp_ret  = 32'h0;
    sb.delete();
    step();
    step();
  endtask

  initial begin
    step();
    step();
    step();
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_inst", inst, 0);
    check("rst_halt", halt, 0);
    check("rst_halt_err", halt_err, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    check("wrap_rst_pc", d2_pc, 32'hFFFF_FFFC);

    reset = 1'b0;
    #1;
    check("idle_no_req", req_valid, 0);
    step();

    do_instr(32'h0010_0093, 0, 1'b0, 1'b0, 1'b0);
    check("wrap_pc", d2_pc, 32'h0);
    check("wrap_req_addr", d2_req_addr, 32'h0);
    check("wrap_req_valid", d2_req_valid, 1);

    do_instr(32'h0020_0113, 5, 1'b0, 1'b0, 1'b0);
    do_instr(32'h0030_0193, 0, 1'b0, 1'b0, 1'b1);
    do_instr(32'h0040_0213, 2, 1'b0, 1'b0, 1'b0);

    // Reset while waiting for a response; the late response lands in IDLE.
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    apply_reset();
    reset      = 1'b0;
    resp_valid = 1'b1;
    resp_err   = 1'b1;
    resp_data  = 32'h0BAD_0BAD;
    step();
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = 32'h0;
    check("stale_inst", inst, 0);
    check("stale_halt", halt, 0);
    check("stale_halt_err", halt_err, 0);
    check("stale_req_addr", req_addr, 32'h8000_0000);
    check("stale_req_valid", req_valid, 1);
    check("stale_cycle_cnt", cycle_cnt, perf(exp_cyc));
    check("stale_retire_cnt", retire_cnt, 0);
    do_instr(32'h0050_0293, 0, 1'b0, 1'b0, 1'b0);

    do_instr(32'h0010_0073, 1, 1'b1, 1'b0, 1'b0);

    apply_reset();
    reset = 1'b0;
    step();
    do_instr(32'h0060_0313, 0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h0070_0393, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      resp_valid = 1'b1;
      resp_data  = 32'h1234_5678;
      req_ready  = 1'b1;
      step();
      check("errhalt_no_req", req_valid, 0);
      check("errhalt_inst", inst, exp_inst);
      check("errhalt_pc", pc, exp_pc);
    end
    check("errhalt_cycle_frozen", cycle_cnt, perf(exp_cyc));
    check("errhalt_retire", retire_cnt, perf(exp_ret));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
